// File: rtl/hier_node_ctrl.sv
// Hierarchy node controller: launches NUM_CHILDREN children sequentially or in parallel and aggregates their completion.
// Latency: LAUNCH is 1 cycle after start_i; best case done_o at +1+2*N (sequential) or +3 (parallel); every output is registered.
// Backpressure: none. start_i is sampled only in IDLE and is never queued; a watchdog ends a WAIT that runs too long.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start_i, mode_i               run request and launch mode (0 sequential, 1 parallel), sampled in IDLE
//   child_start_o, child_done_i   per-child launch pulse and completion (level or pulse)
//   busy_o, done_o, err_o         run in progress, end-of-run pulse, sticky timeout flag
//   active_idx_o, done_mask_o     running child (sequential mode), children completed in this run
module hier_node_ctrl #(
  parameter int NUM_CHILDREN = 5,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 16,
  localparam int IDX_W       = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    mode_i,
  output logic [NUM_CHILDREN-1:0] child_start_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [IDX_W-1:0]        active_idx_o,
  output logic [NUM_CHILDREN-1:0] done_mask_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_CHILDREN - 1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [NUM_CHILDREN-1:0] ALL_DONE = '1;

  state_t                  state_q, state_n;
  logic                    mode_q, mode_n;
  logic [IDX_W-1:0]        idx_n;
  logic [NUM_CHILDREN-1:0] mask_n;
  logic                    err_n;
  logic [CNT_W-1:0]        cnt_q, cnt_n;
  logic [NUM_CHILDREN-1:0] par_mask;
  logic                    seq_hit;
  logic                    wait_done;
  logic                    expired;

  always_comb begin
    state_n   = state_q;
    mode_n    = mode_q;
    idx_n     = active_idx_o;
    mask_n    = done_mask_o;
    err_n     = err_o;
    cnt_n     = cnt_q;
    seq_hit   = child_done_i[active_idx_o];
    par_mask  = done_mask_o | child_done_i;
    wait_done = mode_q ? (par_mask == ALL_DONE) : seq_hit;
    // Completion is checked before expiry so a same-cycle completion wins.
    expired   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_n  = mode_i;
          idx_n   = '0;
          mask_n  = '0;
          err_n   = 1'b0;
          state_n = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wait_done) begin
          if (mode_q) begin
            mask_n  = par_mask;
            state_n = S_DONE;
          end else begin
            mask_n[active_idx_o] = 1'b1;
            if (active_idx_o < LAST_IDX) begin
              idx_n   = active_idx_o + IDX_W'(1);
              state_n = S_LAUNCH;
            end else begin
              state_n = S_DONE;
            end
          end
        end else if (expired) begin
          // Mask is left as it stood before this cycle.
          err_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          if (TIMEOUT != 0) begin
            cnt_n = cnt_q + CNT_W'(1);
          end
          if (mode_q) begin
            mask_n = par_mask;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Pulse/status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      active_idx_o  <= '0;
      done_mask_o   <= '0;
      err_o         <= 1'b0;
      cnt_q         <= '0;
      child_start_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state_q       <= state_n;
      mode_q        <= mode_n;
      active_idx_o  <= idx_n;
      done_mask_o   <= mask_n;
      err_o         <= err_n;
      cnt_q         <= cnt_n;
      child_start_o <= (state_n == S_LAUNCH) ?
                       (mode_n ? ALL_DONE : (NUM_CHILDREN'(1) << idx_n)) : '0;
      busy_o        <= (state_n != S_IDLE);
      done_o        <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_hier_node_ctrl.sv
// Bench for hier_node_ctrl: directed scenarios plus random child completion patterns.
// Expected launch times, end cycle, error and mask come from a timeline model per run.
// All cycle numbers below are relative to the edge that samples start_i (cycle 1 = LAUNCH).
module tb_hier_node_ctrl;

  localparam int N    = 5;
  localparam int TO   = 8;
  localparam int IW   = 3;
  localparam int PMAX = 63;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          mode_i;
  logic [N-1:0]  child_start_o;
  logic [N-1:0]  child_done_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [IW-1:0] active_idx_o;
  logic [N-1:0]  done_mask_o;

  int total = 0;
  int bad   = 0;

  // Stimulus: child_done_i value during relative cycle k.
  logic [N-1:0] pat [0:PMAX];

  // Model results for the current run.
  logic [N-1:0] exp_start [0:PMAX];
  int           exp_idx   [0:PMAX];
  int           exp_done;
  logic         exp_err;
  logic [N-1:0] exp_mask;

  hier_node_ctrl #(.NUM_CHILDREN(N), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .child_start_o(child_start_o),
    .child_done_i (child_done_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .active_idx_o (active_idx_o),
    .done_mask_o  (done_mask_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pat();
    for (int k = 0; k <= PMAX; k++) pat[k] = '0;
  endtask

  task automatic gen_rand(input int dens);
    for (int k = 0; k <= PMAX; k++)
      for (int c = 0; c < N; c++)
        pat[k][c] = ($urandom_range(0, dens) == 0);
  endtask

  // Timeline model: sequential mode walks children one after another, each
  // with its own window of TO wait cycles; parallel mode uses the first
  // arrival of every child inside one window starting at cycle 2.
  task automatic predict(input logic m);
    int  t, lastc, a, maxa;
    bit  found, stop, allf;
    int  fw;
    for (int k = 0; k <= PMAX; k++) begin
      exp_start[k] = '0;
      exp_idx[k]   = 0;
    end
    exp_mask = '0;
    exp_err  = 1'b0;
    if (m == 1'b0) begin
      t = 1; lastc = 0; stop = 0;
      for (int c = 0; c < N; c++) begin
        if (!stop) begin
          exp_start[t] = N'(1) << c;
          lastc = c;
          found = 0; fw = 0;
          for (int w = t + 1; w <= t + TO; w++)
            if (!found && pat[w][c]) begin
              found = 1; fw = w;
            end
          if (found) begin
            for (int k = t; k <= fw; k++) exp_idx[k] = c;
            exp_mask[c] = 1'b1;
            t = fw + 1;
          end else begin
            for (int k = t; k <= t + TO; k++) exp_idx[k] = c;
            t = t + TO + 1;
            exp_err = 1'b1;
            stop = 1;
          end
        end
      end
      exp_done = t;
      exp_idx[t]     = lastc;
      exp_idx[t + 1] = lastc;
    end else begin
      exp_start[1] = '1;
      maxa = 0; allf = 1;
      for (int c = 0; c < N; c++) begin
        a = 0;
        for (int w = 2; w <= 1 + TO; w++)
          if (a == 0 && pat[w][c]) a = w;
        if (a == 0) allf = 0;
        else begin
          if (a > maxa) maxa = a;
          if (a <= TO) exp_mask[c] = 1'b1;
        end
      end
      if (allf) begin
        exp_done = maxa + 1;
        exp_mask = '1;
      end else begin
        exp_done = TO + 2;
        exp_err  = 1'b1;
      end
    end
  endtask

  // started=1: the previous run left start_i high, so the DUT is already in cycle 1.
  task automatic run_case(input logic m, input bit hold, input bit started);
    predict(m);
    if (!started) begin
      start_i = 1'b1;
      mode_i  = m;
      child_done_i = '0;
      step();
    end
    start_i = hold;
    for (int k = 1; k <= exp_done + 1; k++) begin
      chk("child_start", 32'(child_start_o), 32'(exp_start[k]));
      chk("done",        32'(done_o),        32'(k == exp_done));
      chk("busy",        32'(busy_o),        32'(k <= exp_done));
      chk("active_idx",  32'(active_idx_o),  32'(exp_idx[k]));
      if (k >= exp_done) begin
        chk("err",  32'(err_o),       32'(exp_err));
        chk("mask", 32'(done_mask_o), 32'(exp_mask));
      end
      child_done_i = pat[k];
      step();
    end
    child_done_i = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; child_done_i = '0;
    step(); step();
    chk("rst_busy",  32'(busy_o),        32'(0));
    chk("rst_done",  32'(done_o),        32'(0));
    chk("rst_err",   32'(err_o),         32'(0));
    chk("rst_start", 32'(child_start_o), 32'(0));
    chk("rst_mask",  32'(done_mask_o),   32'(0));
    chk("rst_idx",   32'(active_idx_o),  32'(0));
    rst = 1'b0;
    step();

    // Sequential, each child done the cycle after its launch: done_o at 11.
    clear_pat();
    for (int c = 0; c < N; c++) pat[2 + 2 * c] = N'(1) << c;
    run_case(1'b0, 0, 0);
    chk("seq_best_done_cycle", 32'(exp_done), 32'(11));

    // Parallel, arrivals at 3,7,4,9,5: done_o at 10 (9 is the last window cycle).
    clear_pat();
    pat[3][0] = 1'b1; pat[7][1] = 1'b1; pat[4][2] = 1'b1; pat[9][3] = 1'b1; pat[5][4] = 1'b1;
    run_case(1'b1, 0, 0);
    chk("par_done_cycle", 32'(exp_done), 32'(10));

    // Sequential timeout on child 2: mask 00011, children 3 and 4 never launched.
    clear_pat();
    pat[2][0] = 1'b1; pat[4][1] = 1'b1;
    for (int k = 0; k <= PMAX; k++) begin
      pat[k][3] = 1'b1;
      pat[k][4] = 1'b1;
    end
    run_case(1'b0, 0, 0);
    chk("to_mask_model", 32'(exp_mask), 32'(5'b00011));

    // Early done of child 3 while child 1 runs is ignored.
    clear_pat();
    pat[2][0] = 1'b1; pat[4][3] = 1'b1; pat[6][1] = 1'b1;
    pat[8][2] = 1'b1; pat[10][3] = 1'b1; pat[12][4] = 1'b1;
    run_case(1'b0, 0, 0);
    chk("early_done_cycle", 32'(exp_done), 32'(13));

    // Reset in the middle of a parallel WAIT.
    start_i = 1'b1; mode_i = 1'b1; child_done_i = '0;
    step();
    start_i = 1'b0;
    step();
    child_done_i = 5'b00101;
    step(); step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy",  32'(busy_o),        32'(0));
    chk("mid_rst_done",  32'(done_o),        32'(0));
    chk("mid_rst_err",   32'(err_o),         32'(0));
    chk("mid_rst_start", 32'(child_start_o), 32'(0));
    chk("mid_rst_mask",  32'(done_mask_o),   32'(0));
    chk("mid_rst_idx",   32'(active_idx_o),  32'(0));
    rst = 1'b0; child_done_i = '0;
    step();
    chk("post_rst_idle_done", 32'(done_o), 32'(0));
    clear_pat();
    pat[3] = 5'b11111;
    run_case(1'b1, 0, 0);

    // start_i held high: back-to-back runs.
    gen_rand(2);
    run_case(1'b0, 1, 0);
    gen_rand(2);
    run_case(1'b0, 1, 1);
    gen_rand(3);
    run_case(1'b0, 0, 1);
    step();
    chk("hold_end_idle_busy", 32'(busy_o), 32'(0));

    // Random patterns, mixed modes and densities (sparse ones time out).
    for (int r = 0; r < 30; r++) begin
      int dens;
      dens = (r % 3 == 0) ? 14 : ((r % 3 == 1) ? 5 : 1);
      gen_rand(dens);
      run_case(1'($urandom_range(0, 1)), 0, 0);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
